// File: rtl/elastic_pipe_pkg.sv
// Shared helpers for the elastic valid pipeline.
// Holds the occupancy width function; ELASTIC_PIPE_OCCUPANCY_EN is the macro that uses it.
package elastic_pipe_pkg;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One register stage of the elastic pipeline: a valid bit plus a data word.
// The data word loads only when a valid item moves in.
module elastic_pipe_stage
    import elastic_pipe_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             src_vld,
    input  logic [width-1:0] src_data,
    input  logic             dst_rdy,
    output logic             stage_rdy,
    output logic             vld,
    output logic [width-1:0] data
);

    logic             vld_q;
    logic             vld_d;
    logic [width-1:0] data_q;
    logic [width-1:0] data_d;

    // A stage can take a new item if it is empty or its occupant leaves this cycle.
    always_comb begin
        stage_rdy = !vld_q || dst_rdy;
        vld_d     = vld_q;
        data_d    = data_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (stage_rdy) begin
            vld_d = src_vld;
            if (src_vld) begin
                data_d = src_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld  = vld_q;
    assign data = data_q;

endmodule

// File: rtl/elastic_valid_pipeline.sv
// Elastic delay line of depth stages with ready/valid on both ends; bubbles collapse under stall.
// Define ELASTIC_PIPE_OCCUPANCY_EN to add the occupancy (valid popcount) output.
//
// Handshake: a transfer happens on a cycle where valid and ready are both high at the
// rising edge; valid never depends on ready, and in_rdy is combinational from out_rdy.
module elastic_valid_pipeline
    import elastic_pipe_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [width-1:0]              in_data,
    output logic                          out_vld,
    input  logic                          out_rdy,
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    output logic [occ_width(depth)-1:0]   occupancy,
`endif
    output logic [width-1:0]              out_data
);

    logic [depth:0]   rdy;
    logic [depth-1:0] vld;
    logic [width-1:0] data [depth];

    assign rdy[depth] = out_rdy;

    for (genvar g = 0; g < depth; g++) begin : g_stage
        logic             src_vld;
        logic [width-1:0] src_data;

        if (g == 0) begin : g_head
            assign src_vld  = in_vld && !flush;
            assign src_data = in_data;
        end else begin : g_body
            assign src_vld  = vld[g-1];
            assign src_data = data[g-1];
        end

        elastic_pipe_stage #(
            .width (width)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .src_vld   (src_vld),
            .src_data  (src_data),
            .dst_rdy   (rdy[g+1]),
            .stage_rdy (rdy[g]),
            .vld       (vld[g]),
            .data      (data[g])
        );
    end

    assign in_rdy   = rdy[0] && !flush;
    assign out_vld  = vld[depth-1];
    assign out_data = data[depth-1];

`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    localparam int ow = occ_width(depth);
    logic [ow-1:0] occ_cnt;

    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < depth; i++) begin
            occ_cnt = occ_cnt + ow'(vld[i]);
        end
    end

    assign occupancy = occ_cnt;
`endif

endmodule

// File: tb/tb_elastic_valid_pipeline.sv
// Self-checking bench for elastic_valid_pipeline (width=8, depth=4) with a queue scoreboard.
// Occupancy checks are compiled in when ELASTIC_PIPE_OCCUPANCY_EN is defined.
module tb_elastic_valid_pipeline;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_vld;
    logic         in_rdy;
    logic [W-1:0] in_data;
    logic         out_vld;
    logic         out_rdy;
    logic [W-1:0] out_data;
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    logic [2:0]   occupancy;
`endif

    logic [W-1:0] exp_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;

    elastic_valid_pipeline #(
        .width (W),
        .depth (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        .occupancy (occupancy),
`endif
        .out_data  (out_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_occ(input string tag, input int exp);
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        check(tag, 32'(occupancy), 32'(exp));
`endif
    endtask

    // scoreboard: push on input transfer, pop/compare on output transfer
    always @(negedge clk) begin
        if (out_vld && out_rdy) begin
            if (exp_q.size() == 0) check("sb_extra_item", 32'(exp_q.size()), 32'd1);
            else check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        if (in_vld && in_rdy) exp_q.push_back(in_data);
        if (rst || flush) exp_q.delete();
    end

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;

        // reset
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_in_rdy", 32'(in_rdy), 32'd1);
        check_occ("rst_occ", 0);

        // latency: visible exactly depth cycles after accept
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        in_data = 8'h11;
        #1;
        check("lat_in_rdy", 32'(in_rdy), 32'd1);
        step();
        in_vld = 1'b0;
        for (int c = 1; c <= D; c++) begin
            check($sformatf("lat_vld_c%0d", c), 32'(out_vld), 32'(c == D));
            if (c < D) step();
        end
        check("lat_data", 32'(out_data), 32'h11);
        step();
        check("lat_empty", 32'(out_vld), 32'd0);

        // fill and stall
        out_rdy = 1'b0;
        for (int k = 1; k <= D; k++) begin
            in_vld  = 1'b1;
            in_data = W'(k);
            #1;
            check($sformatf("fill_rdy_%0d", k), 32'(in_rdy), 32'd1);
            step();
        end
        in_data = 8'h05;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("full_in_rdy", 32'(in_rdy), 32'd0);
            check("full_out_data", 32'(out_data), 32'h01);
            check("full_out_vld", 32'(out_vld), 32'd1);
            check_occ("full_occ", D);
            if (k == 0) step();
        end

        // drain: pass-through accept in the same cycle
        out_rdy = 1'b1;
        #1;
        check("drain_in_rdy", 32'(in_rdy), 32'd1);
        check("drain_out_01", 32'(out_data), 32'h01);
        step();
        in_vld = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("drain_vld_%0d", k), 32'(out_vld), 32'd1);
            check($sformatf("drain_out_%0d", k), 32'(out_data), 32'(k));
            step();
        end
        check("drain_empty", 32'(out_vld), 32'd0);
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        // bubble collapse
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_data = 8'hA0;
        step();
        in_vld = 1'b0;
        step();
        in_vld  = 1'b1;
        in_data = 8'hB0;
        step();
        in_vld = 1'b0;
        step();
        step();
        check("bub_out_vld", 32'(out_vld), 32'd1);
        check("bub_out_data", 32'(out_data), 32'hA0);
        check("bub_in_rdy", 32'(in_rdy), 32'd1);
        check_occ("bub_occ", 2);

        // third item, then flush with a competing input
        in_vld  = 1'b1;
        in_data = 8'hC0;
        step();
        check_occ("pre_flush_occ", 3);
        flush   = 1'b1;
        in_data = 8'hEE;
        #1;
        check("flush_in_rdy", 32'(in_rdy), 32'd0);
        step();
        flush  = 1'b0;
        in_vld = 1'b0;
        check("flush_out_vld", 32'(out_vld), 32'd0);
        check_occ("flush_occ", 0);
        out_rdy = 1'b1;
        for (int k = 0; k < D + 2; k++) begin
            check("flush_no_ee", 32'(out_vld), 32'd0);
            step();
        end

        // reset mid-drain
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_vld  = 1'b1;
            in_data = W'(8'h31 + k);
            step();
        end
        in_vld = 1'b0;
        step();
        step();
        out_rdy = 1'b1;
        step();
        rst     = 1'b1;
        in_vld  = 1'b1;
        in_data = 8'hEE;
        step();
        rst    = 1'b0;
        in_vld = 1'b0;
        #1;
        check("rst_mid_out_vld", 32'(out_vld), 32'd0);
        check("rst_mid_in_rdy", 32'(in_rdy), 32'd1);
        check_occ("rst_mid_occ", 0);
        for (int k = 0; k < D + 2; k++) begin
            check("rst_mid_no_item", 32'(out_vld), 32'd0);
            step();
        end

        // random traffic with random back-pressure
        for (int n = 0; n < 300; n++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            in_data = W'($urandom_range(0, 255));
            out_rdy = ($urandom_range(0, 2) != 0);
            step();
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
        step();
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_out_vld", 32'(out_vld), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
